// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the rv_pipe_core pipeline.
//   - instruction field bit positions
//   - opcode / funct3 / funct7 encodings
//   - ALU operation enum and decoded control bundle
//   - decode() helper that maps opcode/funct3/funct7 to a control bundle
package rv_pkg;

  localparam int unsigned ILEN = 32;

  // Instruction field bit positions
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_MSB  = 31;
  localparam int unsigned IMM_LSB = 20;
  localparam int unsigned IMM_MSB = 31;

  // Opcodes
  localparam logic [6:0] OPC_ALU = 7'd0;
  localparam logic [6:0] OPC_MEM = 7'd1;
  localparam logic [6:0] OPC_BR  = 7'd2;
  localparam logic [6:0] OPC_SH  = 7'd3;

  // funct7 selecting register-register ALU forms under OPC_ALU
  localparam logic [6:0] F7_REG = 7'd1;

  // funct3 encodings
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SUB = 3'd1;
  localparam logic [2:0] F3_AND = 3'd2;
  localparam logic [2:0] F3_OR  = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SLT = 3'd5;
  localparam logic [2:0] F3_LW  = 3'd0;
  localparam logic [2:0] F3_SW  = 3'd1;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_SLL = 3'd0;
  localparam logic [2:0] F3_SRL = 3'd1;

  // Enum values line up with funct3 for the ALU-class opcodes so the
  // decoder can cast funct3 straight across.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    we;       // writes rd at retirement
    logic    load;
    logic    store;
    logic    branch;
    logic    bne;      // branch sense: 1 = taken on inequality
    logic    use_imm;  // ALU operand b is imm instead of rs2
    alu_op_e op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{we: 1'b0, load: 1'b0, store: 1'b0, branch: 1'b0,
                                 bne: 1'b0, use_imm: 1'b0, op: ALU_ADD};

  // Any combination not listed below falls back to CTRL_NOP.
  function automatic ctrl_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7);
    ctrl_t c;
    c = CTRL_NOP;
    case (opc)
      OPC_ALU: begin
        if (f7 == F7_REG) begin
          if (f3 <= F3_SLT) begin
            c.we = 1'b1;
            c.op = alu_op_e'(f3);
          end else begin
            c = CTRL_NOP;
          end
        end else begin
          if (f3 <= F3_XOR) begin
            c.we      = 1'b1;
            c.use_imm = 1'b1;
            c.op      = alu_op_e'(f3);
          end else begin
            c = CTRL_NOP;
          end
        end
      end
      OPC_MEM: begin
        case (f3)
          F3_LW: begin
            c.we = 1'b1; c.load = 1'b1; c.use_imm = 1'b1; c.op = ALU_ADD;
          end
          F3_SW: begin
            c.store = 1'b1; c.use_imm = 1'b1; c.op = ALU_ADD;
          end
          default: c = CTRL_NOP;
        endcase
      end
      OPC_BR: begin
        case (f3)
          F3_BEQ:  c.branch = 1'b1;
          F3_BNE:  begin c.branch = 1'b1; c.bne = 1'b1; end
          default: c = CTRL_NOP;
        endcase
      end
      OPC_SH: begin
        case (f3)
          F3_SLL:  begin c.we = 1'b1; c.op = ALU_SLL; end
          F3_SRL:  begin c.we = 1'b1; c.op = ALU_SRL; end
          default: c = CTRL_NOP;
        endcase
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_alu.sv
// rv_alu: purely combinational EX-stage arithmetic unit.
//   op  in  ALU operation
//   a   in  operand a (forwarded rs1)
//   b   in  operand b (forwarded rs2 or immediate)
//   y   out result
module rv_alu
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  logic           slt_s;

  // Result select for every ALU operation
  always_comb begin
    shamt_s = b[SHW-1:0];
    slt_s   = $signed(a) < $signed(b);
    y       = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLL: y = a << shamt_s;
      ALU_SRL: y = a >> shamt_s;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rv_pipe_core.sv
// rv_pipe_core: five-stage (IF/ID/EX/MEM/WB) in-order pipeline with
// forwarding, a one-cycle load-use stall and EX-resolved branches.
//   clk         in  clock, all state on rising edge
//   RN          in  asynchronous active-low reset
//   imem_we     in  instruction-memory write strobe (honoured during reset)
//   imem_waddr  in  instruction-memory write address
//   imem_wdata  in  instruction word
//   pc          out address fetched this cycle
//   wb_valid    out retiring register write
//   wb_rd       out destination of the retiring write
//   wb_out      out value written back
//   stall       out IF/ID held for a load-use hazard
//   flush       out taken branch squashing IF/ID and ID/EX
module rv_pipe_core
  import rv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          RN,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          wb_valid,
  output logic [$clog2(NREG)-1:0]       wb_rd,
  output logic [XLEN-1:0]               wb_out,
  output logic                          stall,
  output logic                          flush
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);
  localparam int unsigned RAW = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [IAW-1:0]  pc;
    logic [ILEN-1:0] instr;
  } ifid_t;

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [IAW-1:0]  pc;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic            load;
    logic            store;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] st_data;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] result;
  } memwb_t;

  logic [ILEN-1:0] imem_q [IMEM_DEPTH];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
  logic [XLEN-1:0] rf_q   [NREG];

  logic [IAW-1:0] pc_q, pc_d;
  ifid_t          ifid_q, ifid_d;
  idex_t          idex_q, idex_d;
  exmem_t         exmem_q, exmem_d;
  memwb_t         memwb_q, memwb_d;

  logic [ILEN-1:0] if_instr_s;
  ctrl_t           id_ctrl_s;
  logic [RAW-1:0]  id_rd_s, id_rs1_s, id_rs2_s;
  logic [XLEN-1:0] id_imm_s, id_rs1_val_s, id_rs2_val_s;
  logic            wb_we_s;
  logic [XLEN-1:0] mem_result_s;
  logic [XLEN-1:0] ex_rs1_s, ex_rs2_s, ex_b_s, alu_y_s;
  logic            taken_s, load_use_s;
  logic [IAW-1:0]  target_s;

  // IF: asynchronous read, so a same-cycle write to this address lands after the fetch
  assign if_instr_s = imem_q[pc_q];

  // ID field extraction and decode
  assign id_rd_s   = ifid_q.instr[RD_LSB +: RAW];
  assign id_rs1_s  = ifid_q.instr[RS1_LSB +: RAW];
  assign id_rs2_s  = ifid_q.instr[RS2_LSB +: RAW];
  assign id_imm_s  = {{(XLEN-12){ifid_q.instr[IMM_MSB]}}, ifid_q.instr[IMM_MSB:IMM_LSB]};
  assign id_ctrl_s = decode(ifid_q.instr[OPC_MSB:OPC_LSB], ifid_q.instr[F3_MSB:F3_LSB],
                            ifid_q.instr[F7_MSB:F7_LSB]);

  assign wb_we_s = memwb_q.valid & memwb_q.we;

  // Register read with WB bypass so a same-cycle write is seen by ID
  always_comb begin
    if (id_rs1_s == '0) begin
      id_rs1_val_s = '0;
    end else if (wb_we_s && (memwb_q.rd == id_rs1_s)) begin
      id_rs1_val_s = memwb_q.result;
    end else begin
      id_rs1_val_s = rf_q[id_rs1_s];
    end
    if (id_rs2_s == '0) begin
      id_rs2_val_s = '0;
    end else if (wb_we_s && (memwb_q.rd == id_rs2_s)) begin
      id_rs2_val_s = memwb_q.result;
    end else begin
      id_rs2_val_s = rf_q[id_rs2_s];
    end
  end

  // MEM-stage result; the load data is forwarded from here too, which is
  // what lets a single stall cycle cover load-use
  assign mem_result_s = exmem_q.load ? dmem_q[exmem_q.alu[DAW-1:0]] : exmem_q.alu;

  // EX operand forwarding: MEM stage first, then WB stage, then ID/EX copy
  always_comb begin
    if ((idex_q.rs1 != '0) && exmem_q.valid && exmem_q.we && (exmem_q.rd == idex_q.rs1)) begin
      ex_rs1_s = mem_result_s;
    end else if ((idex_q.rs1 != '0) && wb_we_s && (memwb_q.rd == idex_q.rs1)) begin
      ex_rs1_s = memwb_q.result;
    end else begin
      ex_rs1_s = idex_q.rs1_val;
    end
    if ((idex_q.rs2 != '0) && exmem_q.valid && exmem_q.we && (exmem_q.rd == idex_q.rs2)) begin
      ex_rs2_s = mem_result_s;
    end else if ((idex_q.rs2 != '0) && wb_we_s && (memwb_q.rd == idex_q.rs2)) begin
      ex_rs2_s = memwb_q.result;
    end else begin
      ex_rs2_s = idex_q.rs2_val;
    end
  end

  assign ex_b_s = idex_q.ctrl.use_imm ? idex_q.imm : ex_rs2_s;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .op (idex_q.ctrl.op),
    .a  (ex_rs1_s),
    .b  (ex_b_s),
    .y  (alu_y_s)
  );

  assign taken_s  = idex_q.valid & idex_q.ctrl.branch &
                    ((ex_rs1_s == ex_rs2_s) ^ idex_q.ctrl.bne);
  assign target_s = idex_q.pc + IAW'(1) + idex_q.imm[IAW-1:0];

  // Raw rs fields are compared regardless of whether the ID instruction uses them
  assign load_use_s = idex_q.valid & idex_q.ctrl.load & ifid_q.valid &
                      (((idex_q.rd == id_rs1_s) && (id_rs1_s != '0)) ||
                       ((idex_q.rd == id_rs2_s) && (id_rs2_s != '0)));

  assign flush = taken_s;
  assign stall = load_use_s & ~taken_s;

  // Next-state for pc and all pipeline registers; a taken branch outranks a stall
  always_comb begin
    pc_d         = pc_q + IAW'(1);
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_q;
    ifid_d.instr = if_instr_s;

    idex_d.valid   = ifid_q.valid;
    idex_d.ctrl    = id_ctrl_s;
    idex_d.pc      = ifid_q.pc;
    idex_d.rd      = id_rd_s;
    idex_d.rs1     = id_rs1_s;
    idex_d.rs2     = id_rs2_s;
    idex_d.rs1_val = id_rs1_val_s;
    idex_d.rs2_val = id_rs2_val_s;
    idex_d.imm     = id_imm_s;

    exmem_d.valid   = idex_q.valid;
    exmem_d.we      = idex_q.ctrl.we;
    exmem_d.load    = idex_q.ctrl.load;
    exmem_d.store   = idex_q.ctrl.store;
    exmem_d.rd      = idex_q.rd;
    exmem_d.alu     = alu_y_s;
    exmem_d.st_data = ex_rs2_s;

    memwb_d.valid  = exmem_q.valid;
    memwb_d.we     = exmem_q.we;
    memwb_d.rd     = exmem_q.rd;
    memwb_d.result = mem_result_s;

    if (taken_s) begin
      pc_d         = target_s;
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (load_use_s) begin
      pc_d         = pc_q;
      ifid_d       = ifid_q;
      idex_d.valid = 1'b0;
    end else begin
      pc_d = pc_q + IAW'(1);
    end
  end

  // Pipeline state registers; reset discards everything in flight
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Register file: reset loads REG[i]=i, r0 writes are dropped
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= XLEN'(i);
      end
    end else if (wb_we_s && (memwb_q.rd != '0)) begin
      rf_q[memwb_q.rd] <= memwb_q.result;
    end
  end

  // Instruction memory write port, independent of reset
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[imem_waddr] <= imem_wdata;
    end
  end

  // Data memory write port; stores only issue from a valid MEM stage
  always_ff @(posedge clk) begin
    if (exmem_q.valid && exmem_q.store) begin
      dmem_q[exmem_q.alu[DAW-1:0]] <= exmem_q.st_data;
    end
  end

  assign pc       = pc_q;
  assign wb_valid = wb_we_s;
  assign wb_rd    = memwb_q.rd;
  assign wb_out   = memwb_q.result;

endmodule
